// File: rtl/pbit_pkg.sv
// rtl/pbit_pkg.sv - shared FSM encoding, mode constants and node-order indices for the p-bit multiplier sampler
package pbit_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLAMP  = 3'd1;
    localparam logic [2:0] ST_BURN   = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DECIDE = 3'd4;
    localparam logic [2:0] ST_CHECK  = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Node field index; a field's LSB within a node vector is index * N (p is 2N wide).
    localparam int NODE_A = 0;
    localparam int NODE_B = 1;
    localparam int NODE_P = 2;

    localparam int CNT_W = 16;

    // Majority vote; an exact half (even sample count) resolves to 0.
    function automatic logic decode_bit(input logic [CNT_W-1:0] count, input int samples);
        return ({count, 1'b0} > 17'(samples));
    endfunction

endpackage

// File: rtl/pbit_sample_acc.sv
// rtl/pbit_sample_acc.sv - bank of saturating per-node ones counters
module pbit_sample_acc
    import pbit_pkg::*;
#(
    parameter int NODES = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc_en,
    input  logic [NODES-1:0]       bits,
    output logic [NODES*CNT_W-1:0] counts
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            counts <= '0;
        end else if (inc_en) begin
            for (int i = 0; i < NODES; i++) begin
                if (bits[i] && (counts[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                    counts[i*CNT_W +: CNT_W] <= counts[i*CNT_W +: CNT_W] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pbit_mult_sampler.sv
// rtl/pbit_mult_sampler.sv - sequencer that clamps, anneals, samples and checks a p-bit multiplier network
module pbit_mult_sampler
    import pbit_pkg::*;
#(
    parameter int N         = 2,
    parameter int BURN      = 64,
    parameter int SAMPLES   = 255,
    parameter int MAX_RETRY = 3,
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           MODE,
    input  logic           valid_in,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    input  logic [2*N-1:0] op,
    output logic           ready,
    output logic [2*N-1:0] res,
    output logic           valid_res,
    output logic           sol_ok,
    output logic [RW-1:0]  retries,
    output logic           net_rst,
    output logic           net_run,
    output logic [4*N-1:0] net_clamp_en,
    output logic [4*N-1:0] net_clamp_val,
    input  logic [4*N-1:0] net_state
);

    localparam int NODES = 4 * N;
    localparam int W2    = 2 * N;

    logic [2:0]             state;
    logic [31:0]            phase;
    logic                   mode_q;
    logic [RW-1:0]          retry_cnt;
    logic [NODES-1:0]       dec;
    logic [NODES*CNT_W-1:0] counts;

    logic [N-1:0]  a_d;
    logic [N-1:0]  b_d;
    logic [W2-1:0] p_d;
    logic [W2-1:0] prod;
    logic          ok;

    assign a_d  = dec[NODE_A*N +: N];
    assign b_d  = dec[NODE_B*N +: N];
    assign p_d  = dec[NODE_P*N +: W2];
    assign prod = W2'(a_d) * W2'(b_d);
    assign ok   = (prod == p_d);

    assign ready   = (state == ST_IDLE);
    assign net_rst = (state == ST_CLAMP);
    assign net_run = (state == ST_BURN) || (state == ST_SAMPLE);

    pbit_sample_acc #(
        .NODES (NODES)
    ) u_acc (
        .clk    (CLK),
        .rst    (RST),
        .clr    (state == ST_CLAMP),
        .inc_en (state == ST_SAMPLE),
        .bits   (net_state),
        .counts (counts)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_IDLE;
            phase         <= '0;
            mode_q        <= MODE_FWD;
            retry_cnt     <= '0;
            dec           <= '0;
            res           <= '0;
            valid_res     <= 1'b0;
            sol_ok        <= 1'b0;
            retries       <= '0;
            net_clamp_en  <= '0;
            net_clamp_val <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        mode_q    <= MODE;
                        retry_cnt <= '0;
                        if (MODE == MODE_FWD) begin
                            net_clamp_en  <= {{W2{1'b0}}, {N{1'b1}}, {N{1'b1}}};
                            net_clamp_val <= {{W2{1'b0}}, in2, in1};
                        end else begin
                            net_clamp_en  <= {{W2{1'b1}}, {W2{1'b0}}};
                            net_clamp_val <= {op, {W2{1'b0}}};
                        end
                        state <= ST_CLAMP;
                    end
                end
                ST_CLAMP: begin
                    phase <= '0;
                    state <= (BURN == 0) ? ST_SAMPLE : ST_BURN;
                end
                ST_BURN: begin
                    if (phase == 32'(BURN - 1)) begin
                        phase <= '0;
                        state <= ST_SAMPLE;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (phase == 32'(SAMPLES - 1)) begin
                        phase <= '0;
                        state <= ST_DECIDE;
                    end else begin
                        phase <= phase + 32'd1;
                    end
                end
                ST_DECIDE: begin
                    for (int i = 0; i < NODES; i++) begin
                        dec[i] <= net_clamp_en[i] ? net_clamp_val[i]
                                                  : decode_bit(counts[i*CNT_W +: CNT_W], SAMPLES);
                    end
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!ok && (int'(retry_cnt) < MAX_RETRY)) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= ST_CLAMP;
                    end else begin
                        valid_res <= 1'b1;
                        res       <= (mode_q == MODE_FWD) ? p_d : {b_d, a_d};
                        sol_ok    <= ok;
                        retries   <= retry_cnt;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid_res <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/pbit_mult_sampler.md
PBIT_MULT_SAMPLER -- requirements
Module: pbit_mult_sampler

Interface
REQ-001 The block SHALL declare parameter N, default 2, as the operand width in bits.
REQ-002 The block SHALL declare parameter BURN, default 64, as the number of anneal cycles before sampling.
REQ-003 The block SHALL declare parameter SAMPLES, default 255, as the number of sampling cycles per pass; legal range is 1..65535.
REQ-004 The block SHALL declare parameter MAX_RETRY, default 3, as the number of extra passes allowed after a failed check.
REQ-005 The block SHALL have one clock, CLK (input, 1), and a synchronous, active-high reset, RST (input, 1).
REQ-006 MODE (input, 1): 0 = forward (clamp in1, in2; solve product); 1 = inverse (clamp op; solve factors).
REQ-007 valid_in (input, 1): request strobe, accepted only when ready=1.
REQ-008 in1, in2 (input, N each): forward operands.
REQ-009 op (input, 2N): inverse-mode product to factor.
REQ-010 ready (output, 1): high only in IDLE.
REQ-011 res (output, 2N): forward = product; inverse = {in2_factor, in1_factor}.
REQ-012 valid_res (output, 1): one-cycle result strobe.
REQ-013 sol_ok (output, 1): res passed the arithmetic check; valid whenever valid_res=1.
REQ-014 retries (output, clog2(MAX_RETRY+1)): passes used minus one.
REQ-015 net_rst (output, 1): one-cycle reseed/randomise pulse to the p-bit network.
REQ-016 net_run (output, 1): network update enable.
REQ-017 net_clamp_en and net_clamp_val (output, 4N each): per-node clamp; node order {p[2N-1:0], b[N-1:0], a[N-1:0]}.
REQ-018 net_state (input, 4N): current network node values, same order as the clamp vectors.

Function
REQ-019 The FSM SHALL use the states IDLE, CLAMP, BURN, SAMPLE, DECIDE, CHECK and DONE.
REQ-020 IDLE with valid_in=1 SHALL latch MODE, in1, in2 and op, clear retries, and go to CLAMP.
REQ-021 In forward mode, a and b SHALL be clamped to in1 and in2; in inverse mode, p SHALL be clamped to op; all other clamp bits SHALL be 0.
REQ-022 CLAMP SHALL last 1 cycle with net_rst=1, clear all sample counters, and go to BURN.
REQ-023 BURN SHALL last exactly BURN cycles with net_run=1, and then go to SAMPLE.
REQ-024 SAMPLE SHALL last exactly SAMPLES cycles with net_run=1; each cycle, every node counter SHALL increment when its net_state bit is 1.
REQ-025 Counters SHALL be 16-bit and saturating; they cannot wrap within the legal SAMPLES range.
REQ-026 DECIDE SHALL last 1 cycle and set decoded bit = (2*count > SAMPLES); an even-SAMPLES tie SHALL resolve to 0.
REQ-027 Clamped nodes SHALL decode to their clamp value regardless of their count.
REQ-028 CHECK SHALL last 1 cycle and compute ok = (a*b == p) at full 2N-bit width with no truncation.
REQ-029 In CHECK, if ok=0 and retries<MAX_RETRY, the block SHALL increment retries and go to CLAMP (new pass); otherwise it SHALL go to DONE.
REQ-030 DONE SHALL last 1 cycle: valid_res=1, res = p (forward) or {b,a} (inverse), sol_ok = ok, then return to IDLE.
REQ-031 One pass SHALL last L = BURN+SAMPLES+3 cycles, and valid_res SHALL assert (retries+1)*L cycles after the acceptance edge.
REQ-032 res, sol_ok and retries SHALL hold their values until the next DONE.
REQ-033 valid_in while ready=0 SHALL be ignored and not queued.
REQ-034 Inverse requests with op > (2^N-1)^2 SHALL exhaust all retries and end with sol_ok=0.
REQ-035 op=0 SHALL be accepted; any decode with a=0 or b=0 SHALL pass the check.

Reset
REQ-036 When RST=1 at a CLK edge, the block SHALL enter IDLE with ready=1 and valid_res=0.
REQ-037 Reset SHALL also clear res, sol_ok, retries, net_rst, net_run, all clamp outputs and all counters.
REQ-038 A reset mid-operation SHALL abort the request, produce no valid_res, and leave the block able to accept a request on the first cycle after RST falls.

Structure
REQ-039 A shared package pbit_pkg SHALL hold the FSM state encoding, the MODE_FWD=0 and MODE_INV=1 constants, and the node-order index constants.
REQ-040 The counter bank SHALL be a sub-module, pbit_sample_acc, with 4N saturating counters, synchronous clear, and an increment enable.

Verification
REQ-041 N=2, BURN=4, SAMPLES=7, with a network stub that converges to the correct answer: forward in1=3, in2=2 -> res=4'b0110, sol_ok=1, retries=0, valid_res 14 cycles after acceptance.
REQ-042 Inverse op=4'h6 -> res in {4'b1011, 4'b1110}, sol_ok=1.
REQ-043 Inverse op=4'hF (unsatisfiable) -> sol_ok=0, retries=3, valid_res 56 cycles after acceptance, net_rst pulsed 4 times.
REQ-044 Stub wrong on the first pass only, forward 2x2 -> retries=1, res=4'b0100, sol_ok=1, latency 28 cycles.
REQ-045 valid_in pulsed during SAMPLE with different operands -> ignored; the original result is returned unchanged.
REQ-046 RST asserted mid-SAMPLE -> no valid_res, all outputs at reset values; a new request then completes normally.
REQ-047 SAMPLES=8 with the stub holding a node at exactly 4 ones -> that bit decodes to 0.
